// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_RSVD  = 4'b1011;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    localparam int unsigned FLAG_ZERO    = 0;
    localparam int unsigned FLAG_CARRY   = 1;
    localparam int unsigned FLAG_OVF     = 2;
    localparam int unsigned FLAG_ILLEGAL = 3;
    localparam int unsigned FLAG_DIV0    = 4;
    localparam int unsigned NFLAGS       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops with aluop[3:2]==11 run on the iterative mul/div core.
    function automatic logic is_iter_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// The first step runs on the start cycle, so done pulses WIDTH cycles after start.
module alu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic             is_div_q, is_div_d, busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_dvs;
    logic             cur_div;
    logic [CW-1:0]    cur_cnt;
    logic [WIDTH:0]   shifted, madd;
    logic [WIDTH-1:0] trial;
    logic             ge;

    // Mul keeps {hi,lo} as the product register with multiplier in lo;
    // div keeps remainder in hi and shifts the dividend out of lo as quotient bits go in.
    assign cur_hi  = start ? '0 : hi_q;
    assign cur_lo  = start ? (is_div ? a : b) : lo_q;
    assign cur_dvs = start ? (is_div ? b : a) : dvs_q;
    assign cur_div = start ? is_div : is_div_q;
    assign cur_cnt = start ? '0 : cnt_q;

    assign shifted = {cur_hi, cur_lo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, cur_dvs};
    assign trial   = shifted[WIDTH-1:0] - cur_dvs;
    assign madd    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_dvs} : '0);

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        dvs_d    = dvs_q;
        is_div_d = is_div_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (start || busy_q) begin
            if (cur_div) begin
                hi_d = ge ? trial : shifted[WIDTH-1:0];
                lo_d = {cur_lo[WIDTH-2:0], ge};
            end else begin
                {hi_d, lo_d} = {madd, cur_lo[WIDTH-1:1]};
            end
            dvs_d    = cur_dvs;
            is_div_d = cur_div;
            cnt_d    = cur_cnt + CW'(1);
            busy_d   = 1'b1;
            if (cur_cnt == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dvs_q    <= dvs_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative MUL/MULHU/DIVU/REMU,
// one transaction in flight, registered result and flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             div0_q, div0_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    logic             accept_c, start_c;
    logic [WIDTH:0]   add_c, sub_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] alu_res_c, iter_res_c;
    logic [4:0]       alu_flags_c;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign accept_c = in_valid & in_ready_q;
    assign start_c  = accept_c & is_iter_op(aluop);
    assign add_c    = {1'b0, a} + {1'b0, b};
    assign sub_c    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign shamt_c  = b[SHW-1:0];

    // Single-cycle datapath evaluated on the live operands at accept.
    always_comb begin
        alu_res_c   = '0;
        alu_flags_c = '0;
        case (aluop)
            OP_AND:  alu_res_c = a & b;
            OP_OR:   alu_res_c = a | b;
            OP_XOR:  alu_res_c = a ^ b;
            OP_NOR:  alu_res_c = ~(a | b);
            OP_ADD: begin
                alu_res_c               = add_c[WIDTH-1:0];
                alu_flags_c[FLAG_CARRY] = add_c[WIDTH];
                alu_flags_c[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (add_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c               = sub_c[WIDTH-1:0];
                alu_flags_c[FLAG_CARRY] = sub_c[WIDTH];
                alu_flags_c[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res_c = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res_c = WIDTH'(a < b);
            OP_SLL:  alu_res_c = a << shamt_c;
            OP_SRL:  alu_res_c = a >> shamt_c;
            OP_SRA:  alu_res_c = WIDTH'($signed(a) >>> shamt_c);
            OP_RSVD: alu_flags_c[FLAG_ILLEGAL] = 1'b1;
            default: alu_res_c = '0;
        endcase
        alu_flags_c[FLAG_ZERO] = (alu_res_c == '0);
    end

    always_comb begin
        case (op_q)
            OP_MUL, OP_DIVU: iter_res_c = iter_lo;
            default:         iter_res_c = iter_hi;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        div0_d      = div0_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d   = aluop;
                    div0_d = (b == '0) && (aluop[3:1] == 3'b111);
                    if (is_iter_op(aluop)) begin
                        state_d = ST_BUSY;
                    end else begin
                        result_d    = alu_res_c;
                        flags_d     = alu_flags_c;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    result_d            = iter_res_c;
                    flags_d             = '0;
                    flags_d[FLAG_DIV0]  = div0_q;
                    flags_d[FLAG_ZERO]  = (iter_res_c == '0);
                    out_valid_d         = 1'b1;
                    state_d             = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AND;
            div0_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            div0_q      <= div0_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .is_div (aluop[1]),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
